xps2_rx: RTL

Memory-mapped PS/2 keyboard receiver that sits as a responder on the controller's data bus (`sel`/`we`/`addr`/`data_to_wr`/`data_to_rd`). It deserializes PS/2 device-to-host frames from a pad pair, validates start, parity and stop bits, and queues good scancodes in a small FIFO. Software pops the FIFO through RDW/WRW accesses to three local registers. It is the keyboard front end of the calculator.

---
 rtl/xps2_rx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/xps2_rx.sv
// PS/2 keyboard receiver on the controller data bus. Filters the pad clock, deframes
// device-to-host frames and queues good scancodes in a FIFO that software pops through DATA.
module xps2_rx #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int FILT_LEN   = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] data_to_wr,
    output logic [DATA_W-1:0] data_to_rd,
    output logic              irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rxState_t;

    logic [1:0]    r_clkSync, r_dataSync;
    logic          r_filtClk;
    logic [FW-1:0] r_filtCnt;
    logic          w_fall, w_strobe, w_bit;

    rxState_t      r_state, w_nextState;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitCnt;
    logic          r_parity;
    logic [TW-1:0] r_timer;
    logic          w_frameEnd, w_timeout, w_parOk, w_good;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr, r_rdPtr;
    logic [AW:0]   r_count;
    logic [3:0]    w_count4;
    logic          w_empty, w_full, w_push, w_pop, w_setOvf, w_setPerr, w_setFerr;

    logic          r_en, r_ie, r_ovf, r_perr, r_ferr, r_irq;
    logic          w_ctrlWr, w_clrFlags;
    logic          w_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk};
            r_dataSync <= {r_dataSync[0], ps2_data};
        end
    end

    // Filtered clock only follows the pad after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filtClk <= 1'b1;
            r_filtCnt <= '0;
        end else if (r_clkSync[1] == r_filtClk) begin
            r_filtCnt <= '0;
        end else if (r_filtCnt == FW'(FILT_LEN - 1)) begin
            r_filtClk <= r_clkSync[1];
            r_filtCnt <= '0;
        end else begin
            r_filtCnt <= r_filtCnt + FW'(1);
        end
    end

    assign w_fall   = r_filtClk & ~r_clkSync[1] & (r_filtCnt == FW'(FILT_LEN - 1));
    assign w_strobe = w_fall & r_en;
    assign w_bit    = r_dataSync[1];

    assign w_timeout = (r_state != IDLE) && (r_timer == TW'(TIMEOUT));

    always_comb begin
        w_nextState = r_state;
        w_frameEnd  = 1'b0;
        if (!r_en) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_strobe && !w_bit) w_nextState = DATA;
                DATA:    if (w_strobe && r_bitCnt == 3'd7) w_nextState = PARITY;
                PARITY:  if (w_strobe) w_nextState = STOP;
                STOP: begin
                    if (w_strobe) begin
                        w_nextState = IDLE;
                        w_frameEnd  = 1'b1;
                    end
                end
                default: w_nextState = IDLE;
            endcase
            if (!w_strobe && w_timeout) w_nextState = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_parity <= 1'b0;
            r_timer  <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE || w_strobe || w_timeout) r_timer <= '0;
            else                                          r_timer <= r_timer + TW'(1);
            if (w_strobe) begin
                case (r_state)
                    IDLE:    r_bitCnt <= '0;
                    DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                    end
                    PARITY:  r_parity <= w_bit;
                    default: ;
                endcase
            end
        end
    end

    assign w_parOk   = ^{r_shift, r_parity};
    assign w_good    = w_frameEnd & w_parOk & w_bit;
    assign w_setPerr = w_frameEnd & ~w_parOk;
    assign w_setFerr = w_frameEnd & ~w_bit;

    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (AW + 1)'(FIFO_DEPTH));
    assign w_pop    = sel & ~we & (addr == 2'd1) & ~w_empty;
    assign w_push   = w_good & (~w_full | w_pop);
    assign w_setOvf = w_good & w_full & ~w_pop;
    assign w_count4 = 4'(r_count);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_ctrlWr   = sel & we & (addr == 2'd2);
    assign w_clrFlags = w_ctrlWr & data_to_wr[1];

    // Flag set wins over a same-edge software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en   <= 1'b1;
            r_ie   <= 1'b0;
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            if (w_ctrlWr) begin
                r_en <= data_to_wr[0];
                r_ie <= data_to_wr[2];
            end
            r_ovf  <= w_setOvf  | (r_ovf  & ~w_clrFlags);
            r_perr <= w_setPerr | (r_perr & ~w_clrFlags);
            r_ferr <= w_setFerr | (r_ferr & ~w_clrFlags);
            r_irq  <= r_ie & ~w_empty;
        end
    end

    assign irq = r_irq;

    always_comb begin
        data_to_rd = '0;
        if (sel && !we) begin
            case (addr)
                2'd0: data_to_rd = DATA_W'({20'd0, w_count4, 3'd0, r_ferr, r_perr, r_ovf, w_full, ~w_empty});
                2'd1: if (!w_empty) data_to_rd = DATA_W'({23'd0, 1'b1, r_mem[r_rdPtr]});
                2'd2: data_to_rd = DATA_W'({29'd0, r_ie, 1'b0, r_en});
                default: data_to_rd = '0;
            endcase
        end
    end

    assign w_unused = &{1'b0, data_to_wr[DATA_W-1:3]};

endmodule
